// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    modport master (output s_valid, s_data, s_last, input s_ready, wr_en, wr_addr, wr_data);
    modport slave  (input s_valid, s_data, s_last, output s_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into words, writes them to
// instruction memory, appends the 0xFFFFFFFF halt word, then releases the CPU.
module imem_loader #(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    imem_loader_if.slave     bus,
    input  logic             i_reload,
    output logic             o_cpu_reset,
    output logic             o_done,
    output logic             o_error,
    output logic [CNT_W-1:0] o_word_count
);
    typedef enum logic [2:0] {LOAD, TERM, TERM_WR, DONE, ERROR} state_t;
    state_t           r_state;
    logic             r_s_ready;
    logic             r_wr_en;
    logic [63:0]      r_wr_addr;
    logic [31:0]      r_wr_data;
    logic             r_cpu_reset;
    logic             r_done;
    logic             r_error;
    logic [CNT_W-1:0] r_word_count;
    logic [1:0]       r_byte_idx;
    logic [23:0]      r_buf;
    logic             w_accept;
    logic             w_full;
    logic [63:0]      w_addr;
    assign w_accept = bus.s_valid & r_s_ready;
    assign w_full   = r_word_count == CNT_W'(MAX_WORDS - 1);
    assign w_addr   = {{(62 - CNT_W){1'b0}}, r_word_count, 2'b00};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= LOAD;
            r_s_ready    <= 1'b1;
            r_cpu_reset  <= 1'b1;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
            r_byte_idx   <= '0;
            r_buf        <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                LOAD: if (w_accept) begin
                    // the terminator must still fit, so the last slot can never hold image data
                    if (w_full || (bus.s_last && r_byte_idx != 2'd3)) begin
                        r_state   <= ERROR;
                        r_s_ready <= 1'b0;
                        r_error   <= 1'b1;
                    end else begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_wr_en      <= 1'b1;
                            r_wr_data    <= {bus.s_data, r_buf};
                            r_wr_addr    <= w_addr;
                            r_word_count <= r_word_count + 1'b1;
                            if (bus.s_last) begin
                                r_state   <= TERM;
                                r_s_ready <= 1'b0;
                            end
                        end else begin
                            r_buf[{r_byte_idx, 3'b000} +: 8] <= bus.s_data;
                        end
                    end
                end
                TERM: begin
                    r_wr_en   <= 1'b1;
                    r_wr_data <= 32'hFFFF_FFFF;
                    r_wr_addr <= w_addr;
                    r_state   <= TERM_WR;
                end
                TERM_WR: begin
                    r_state     <= DONE;
                    r_done      <= 1'b1;
                    r_cpu_reset <= 1'b0;
                end
                default: if (i_reload) begin
                    r_state      <= LOAD;
                    r_s_ready    <= 1'b1;
                    r_cpu_reset  <= 1'b1;
                    r_done       <= 1'b0;
                    r_error      <= 1'b0;
                    r_word_count <= '0;
                    r_byte_idx   <= '0;
                    r_wr_addr    <= '0;
                    r_wr_data    <= '0;
                end
            endcase
        end
    end
    assign bus.s_ready   = r_s_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign o_cpu_reset   = r_cpu_reset;
    assign o_done        = r_done;
    assign o_error       = r_error;
    assign o_word_count  = r_word_count;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; each expected write carries the cycle it must appear in.
module tb_imem_loader;
    localparam int MAXW = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reload = 1'b0;
    logic        cpu_reset, done, error;
    logic [15:0] word_count;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          m_idx = 0;
    int          m_wc = 0;
    logic [31:0] m_buf = '0;
    logic [127:0] exp_q[$];
    logic [7:0]  img1[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    logic [7:0]  img2[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    imem_loader_if bus ();
    imem_loader #(.MAX_WORDS(MAXW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .i_reload(reload),
        .o_cpu_reset(cpu_reset), .o_done(done), .o_error(error), .o_word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (bus.wr_en === 1'b1) begin
        logic [127:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check("wr", {cyc, bus.wr_addr, bus.wr_data}, e);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_idx = 0;
        m_wc  = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int t = 0;
        int e;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        bus.s_last  = last;
        while (bus.s_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        check("rdy", bus.s_ready, 1);
        e = cyc + 1;
        if (!(m_wc == MAXW - 1 || (last && m_idx != 3))) begin
            m_buf[m_idx*8 +: 8] = b;
            if (m_idx == 3) begin
                exp_q.push_back({e, 64'(m_wc * 4), m_buf});
                m_wc++;
                if (last) exp_q.push_back({e + 1, 64'(m_wc * 4), 32'hFFFF_FFFF});
            end
            m_idx = (m_idx + 1) % 4;
        end
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        model_clear();
    endtask

    task automatic wait_done();
        int t = 0;
        while (done !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        check("done", done, 1);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy_cpu", {bus.s_ready, cpu_reset, bus.wr_en, done, error}, 5'b11000);
        check("rst_wr", {bus.wr_addr, bus.wr_data, word_count}, '0);
        reset = 1'b1;
        tick();
        // image with s_valid held high; done exactly three cycles after the last accept
        for (int i = 0; i < 8; i++) send(img1[i], i == 7);
        check("s1_n1", {bus.s_ready, done}, 2'b00);
        tick();
        check("s1_n2", done, 0);
        tick();
        check("s1_n3", {done, cpu_reset, error}, 3'b100);
        check("s1_wc", word_count, 2);
        pulse_reload();
        check("rl_state", {cpu_reset, done, bus.s_ready}, 3'b101);
        // same image with idle cycles between bytes
        for (int i = 0; i < 8; i++) begin
            send(img1[i], i == 7);
            tick();
        end
        wait_done();
        check("s2_wc", word_count, 2);
        pulse_reload();
        // ragged image: one word, then error with no terminator
        for (int i = 0; i < 6; i++) send(img1[i], i == 5);
        check("s3_err", {error, bus.s_ready, cpu_reset, done}, 4'b1010);
        repeat (3) tick();
        check("s3_sticky", {error, bus.s_ready, word_count}, {2'b10, 16'd1});
        pulse_reload();
        // overflow with MAX_WORDS=4
        for (int i = 0; i < 13; i++) send(8'(i + 1), 1'b0);
        check("s4_err", {error, bus.s_ready, cpu_reset}, 3'b101);
        check("s4_wc", word_count, 3);
        repeat (3) tick();
        pulse_reload();
        // reset mid-load drops the partial word
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b0);
        reset = 1'b0;
        #2;
        check("s5_async", {bus.s_ready, word_count, bus.wr_addr}, {1'b1, 80'd0});
        tick();
        reset = 1'b1;
        model_clear();
        tick();
        for (int i = 0; i < 8; i++) send(img1[i], i == 7);
        wait_done();
        check("s5_wc", word_count, 2);
        // reload with a byte offered in the same cycle, which must be ignored
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        pulse_reload();
        bus.s_valid = 1'b0;
        check("s6_rl", {cpu_reset, done, bus.s_ready, error}, 4'b1010);
        check("s6_wc", word_count, 0);
        for (int i = 0; i < 4; i++) send(img2[i], i == 3);
        tick();
        tick();
        check("s6_done", {done, cpu_reset}, 2'b10);
        check("s6_wc1", word_count, 1);
        repeat (3) tick();
        check("q_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
